btn_cmd_decoder: RTL and testbench
==================================

# btn_cmd_decoder

Debounces one raw active-low pushbutton and turns it into single-cycle user commands for the clock core: a short press, a long press, and an auto-repeat pulse train while the button stays held. It is the input-side counterpart of the display path. The clock core consumes these pulses for mode stepping and for hour/minute increments. One instance is used per physical key, clocked from the 50 MHz board clock.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 2000000: number of consecutive stable cycles required before the debounced level changes (40 ms at 50 MHz).
- LONG_CYCLES, 50000000: debounced-hold duration that qualifies as a long press (1 s).
- REPEAT_CYCLES, 12500000: auto-repeat period once a long press is recognised (250 ms).
- All internal counters are 26 bits wide. Every parameter must be ≥2 and <2^26.

Ports:
- clk, in, 1: system clock; all logic is on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- btn_n, in, 1: raw pushbutton, active-low, asynchronous to clk.
- repeat_en, in, 1: enables auto-repeat pulses in the HELD state. It is sampled every cycle.
- pressed, out, 1: debounced level, 1 = button held.
- short_press, out, 1: one-cycle pulse marking a press released before LONG_CYCLES.
- long_press, out, 1: one-cycle pulse marking that the hold reached LONG_CYCLES.
- repeat_pulse, out, 1: one-cycle pulse every REPEAT_CYCLES in HELD while repeat_en=1.
- hold_active, out, 1: high while the FSM is in HELD.

## Operation
- Synchroniser: btn_n passes through two flops, and the result is inverted to form btn_s (1 = pressed). The flops reset to btn_s=0.
- Debounce:
  - deb_cnt increments on every cycle that btn_s differs from pressed.
  - deb_cnt clears on any cycle where btn_s equals pressed.
  - On a cycle where btn_s still differs and deb_cnt equals DEBOUNCE_CYCLES-1, pressed toggles and deb_cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles therefore never changes pressed.
- FSM states: IDLE, DOWN, HELD.
  - IDLE → DOWN when pressed rises; hold_cnt clears to 0.
  - DOWN: hold_cnt increments every cycle.
    - If hold_cnt = LONG_CYCLES-1 while pressed=1, assert long_press, clear rep_cnt and go to HELD.
    - If pressed falls first, assert short_press and go to IDLE.
  - HELD: rep_cnt increments every cycle.
    - When rep_cnt = REPEAT_CYCLES-1, rep_cnt clears, and repeat_pulse asserts if repeat_en=1.
    - When repeat_en=0, the counter keeps running but no pulse is emitted.
    - pressed falling → IDLE, with no short_press.
- Simultaneous events:
  - In DOWN, if the long threshold and the release of pressed coincide, long_press wins. No short_press is emitted, and the FSM goes to IDLE rather than HELD.
  - At most one of short_press, long_press and repeat_pulse is high in any cycle.
- Reset mid-operation:
  - All state returns to the reset values.
  - A button still held when reset releases is treated as a fresh press. pressed rises only after the full synchroniser plus debounce delay.

## Timing
- Reset values: pressed=0, short_press=0, long_press=0, repeat_pulse=0, hold_active=0, FSM=IDLE, all counters 0.
- All outputs are registered, so there is no combinational path from any input to any output.
- Raw edge to pressed: a stable change of btn_n is reflected in pressed 2+DEBOUNCE_CYCLES cycles later.
- long_press rises LONG_CYCLES cycles after the cycle in which pressed first reads 1.
- hold_active rises together with long_press and falls the cycle after pressed falls.
- short_press is high for exactly one cycle, the cycle after pressed reads 0.
- First repeat_pulse comes REPEAT_CYCLES cycles after long_press. Subsequent pulses follow every REPEAT_CYCLES cycles.
- Counters never wrap: each one is cleared at its threshold or on a state change.

## Test plan
Use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5 unless stated otherwise.
1. Reset: rst_n low with btn_n=0, then release → all outputs 0. pressed rises 6 cycles after release of reset. Asserting rst_n mid-HELD clears hold_active and pressed immediately (asynchronously).
2. Glitch rejection: btn_n low for 3 cycles, high again → pressed never rises and no pulses. Low for 4 or more cycles → pressed rises 6 cycles after the falling edge.
3. Short press: pressed held for 10 cycles, then released → exactly one short_press, the cycle after pressed falls. No long_press.
4. Long press with repeat: repeat_en=1 and held for 40 cycles after pressed rises → long_press at cycle 20, then repeat_pulse at cycles 25, 30, 35 and 40. hold_active stays high throughout. On release: no short_press, and the FSM returns to IDLE.
5. Repeat gating: same as scenario 4 with repeat_en dropped at cycle 27 → the pulse at 25 is present, the pulses at 30 and 35 are absent. Raising repeat_en at cycle 36 restores the pulse at 40.
6. Boundary: pressed falls in exactly the cycle that hold_cnt reaches 19 → one long_press, zero short_press, hold_active never high, FSM in IDLE.

Source files
------------

// File: rtl/btn_cmd_decoder.sv
// btn_cmd_decoder
// Turns one raw active-low pushbutton into debounced level plus single-cycle
// command pulses: short press, long press and auto-repeat while held.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | button released, waiting for the debounced level to rise
//   ST_DOWN  | press accepted, hold_cnt timing the press against LONG_CYCLES
//   ST_HELD  | long press recognised, rep_cnt pacing the auto-repeat ticks
//
// Every output is a flop; the synchroniser and debounce stages sit between the
// pin and any decision, so there is no combinational input-to-output path.

module btn_cmd_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    input  logic repeat_en,
    output logic pressed,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic hold_active
);

    localparam int unsigned CNT_W = 26;

    // Terminal counts; each counter is compared against its last value and
    // cleared there, so none of them can ever wrap.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser: btn_n is asynchronous to clk. Both flops reset to the
    // released level so a key held through reset looks like a new press.
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       btn_s;

    // Two-flop synchroniser on the raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n};
        end
    end

    assign btn_s = ~sync_q[1];

    // ------------------------------------------------------------------
    // Debounce: pressed follows btn_s only after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement; any agreeing cycle restarts it.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] deb_cnt_nxt;
    logic             pressed_nxt;

    // Next debounce count and debounced level.
    always_comb begin
        deb_cnt_nxt = '0;
        pressed_nxt = pressed;
        if (btn_s != pressed) begin
            if (deb_cnt == DEB_LAST) begin
                pressed_nxt = btn_s;
            end else begin
                deb_cnt_nxt = deb_cnt + CNT_ONE;
            end
        end
    end

    // Debounce registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            pressed <= 1'b0;
        end else begin
            deb_cnt <= deb_cnt_nxt;
            pressed <= pressed_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Command FSM.
    // IDLE leaves on the same edge that pressed rises (it looks at
    // pressed_nxt), so DOWN starts with hold_cnt=0 in the first cycle that
    // pressed reads 1 and long_press lands exactly LONG_CYCLES later.
    // Releases are seen through the registered pressed, which puts
    // short_press and the fall of hold_active one cycle after pressed falls.
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_cnt_nxt;
    logic             short_nxt;
    logic             long_nxt;
    logic             repeat_nxt;
    logic             hold_nxt;

    // Next state, counters and command pulses.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        rep_cnt_nxt  = rep_cnt;
        short_nxt    = 1'b0;
        long_nxt     = 1'b0;
        repeat_nxt   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                hold_cnt_nxt = '0;
                rep_cnt_nxt  = '0;
                if (pressed_nxt) begin
                    state_nxt = ST_DOWN;
                end
            end

            ST_DOWN: begin
                // Reaching the long threshold beats a release in the same
                // cycle: the press still counts as long, but with the key
                // already up there is nothing to hold, so back to IDLE.
                if (hold_cnt == LONG_LAST) begin
                    long_nxt     = 1'b1;
                    hold_cnt_nxt = '0;
                    rep_cnt_nxt  = '0;
                    state_nxt    = pressed ? ST_HELD : ST_IDLE;
                end else if (!pressed) begin
                    short_nxt    = 1'b1;
                    hold_cnt_nxt = '0;
                    state_nxt    = ST_IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt + CNT_ONE;
                end
            end

            ST_HELD: begin
                // Once the key is up no further repeat tick is issued, even
                // if the repeat period happens to expire in the same cycle.
                if (!pressed) begin
                    rep_cnt_nxt = '0;
                    state_nxt   = ST_IDLE;
                end else if (rep_cnt == REP_LAST) begin
                    rep_cnt_nxt = '0;
                    repeat_nxt  = repeat_en;
                end else begin
                    rep_cnt_nxt = rep_cnt + CNT_ONE;
                end
            end

            default: begin
                hold_cnt_nxt = '0;
                rep_cnt_nxt  = '0;
                state_nxt    = ST_IDLE;
            end
        endcase

        hold_nxt = (state_nxt == ST_HELD);
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            rep_cnt  <= rep_cnt_nxt;
        end
    end

    // Registered command outputs; each is decided by a distinct FSM branch,
    // so at most one pulse is high in any cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            hold_active  <= 1'b0;
        end else begin
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            repeat_pulse <= repeat_nxt;
            hold_active  <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_btn_cmd_decoder.sv
// Testbench for btn_cmd_decoder with small timing parameters.
// A timestamp-based reference model predicts every output cycle by cycle.

module tb_btn_cmd_decoder;

    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_n = 1'b1;
    logic repeat_en = 1'b0;
    logic pressed, short_press, long_press, repeat_pulse, hold_active;

    int tests = 0;
    int fails = 0;

    btn_cmd_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_n       (btn_n),
        .repeat_en   (repeat_en),
        .pressed     (pressed),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .hold_active (hold_active)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Raw pin delayed two edges, a run length of disagreeing samples for
    // debounce, then press bookkeeping by timestamps (press start, last tick).
    bit h1 = 1'b1, h2 = 1'b1;
    bit m_pressed = 1'b0;
    int m_run = 0;
    int cyc = 0;
    bit active = 1'b0, long_done = 1'b0, holding = 1'b0;
    int m_start = 0, last_tick = 0;
    bit e_short = 1'b0, e_long = 1'b0, e_rep = 1'b0;

    task automatic model_step();
        bit bs, prev_p;
        if (!rst_n) begin
            h1 = 1'b1; h2 = 1'b1; m_pressed = 1'b0; m_run = 0; cyc = 0;
            active = 1'b0; long_done = 1'b0; holding = 1'b0;
            e_short = 1'b0; e_long = 1'b0; e_rep = 1'b0;
        end else begin
            cyc++;
            prev_p = m_pressed;
            bs = !h2;
            h2 = h1;
            h1 = btn_n;
            if (bs != m_pressed) begin
                m_run++;
                if (m_run == DEB) begin
                    m_pressed = bs;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            e_short = 1'b0; e_long = 1'b0; e_rep = 1'b0;
            if (active) begin
                if (!long_done) begin
                    if (cyc == m_start + LNG) begin
                        e_long = 1'b1;
                        long_done = 1'b1;
                        last_tick = cyc;
                        if (prev_p) holding = 1'b1;
                        else active = 1'b0;
                    end else if (!prev_p) begin
                        e_short = 1'b1;
                        active = 1'b0;
                    end
                end else begin
                    if (!prev_p) begin
                        holding = 1'b0;
                        active = 1'b0;
                    end else if (cyc - last_tick == REP) begin
                        e_rep = repeat_en;
                        last_tick = cyc;
                    end
                end
            end
            if (!active && m_pressed) begin
                active = 1'b1;
                long_done = 1'b0;
                m_start = cyc;
            end
        end
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    function automatic logic [4:0] exp_vec();
        return {m_pressed, e_short, e_long, e_rep, holding};
    endfunction

    function automatic logic [4:0] outs();
        return {pressed, short_press, long_press, repeat_pulse, hold_active};
    endfunction

    // ---------------- press runner (records, no verdicts) ----------------
    int r_rise, r_fall, r_long_at, r_n_long, r_short_at, r_n_short;
    int r_hold_first, r_hold_last, r_n_hold, r_mm;
    int rep_times[$];

    // Holds the key low for low_n sampled edges, runs total cycles; repeat_en
    // drops/rises at the given cycle offsets from the press (-1 = never).
    task automatic run_press(input int low_n, input int total, input int en_off, input int en_on);
        r_rise = -1; r_fall = -1; r_long_at = -1; r_n_long = 0;
        r_short_at = -1; r_n_short = 0; r_hold_first = -1; r_hold_last = -1;
        r_n_hold = 0; r_mm = 0;
        rep_times.delete();
        btn_n = 1'b0;
        repeat_en = 1'b1;
        for (int i = 1; i <= total; i++) begin
            @(negedge clk);
            if (outs() !== exp_vec()) r_mm++;
            if ((int'(short_press) + int'(long_press) + int'(repeat_pulse)) > 1) r_mm++;
            if (pressed === 1'b1 && r_rise < 0) r_rise = i;
            if (pressed === 1'b0 && r_rise >= 0 && r_fall < 0) r_fall = i;
            if (long_press === 1'b1) begin
                r_n_long++;
                if (r_long_at < 0) r_long_at = i;
            end
            if (short_press === 1'b1) begin
                r_n_short++;
                if (r_short_at < 0) r_short_at = i;
            end
            if (repeat_pulse === 1'b1) rep_times.push_back(i - r_rise);
            if (hold_active === 1'b1) begin
                r_n_hold++;
                if (r_hold_first < 0) r_hold_first = i;
                r_hold_last = i;
            end
            btn_n = (i >= low_n);
            if (r_rise >= 0 && i - r_rise == en_off) repeat_en = 1'b0;
            if (r_rise >= 0 && i - r_rise == en_on) repeat_en = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int rise;
        rise = -1;
        rst_n = 1'b0; btn_n = 1'b0; repeat_en = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (outs() !== 5'b0) begin
            fails++; $display("FAIL reset_values: got %b want 00000", outs());
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            tests++;
            if (outs() !== exp_vec()) begin
                fails++; $display("FAIL reset_model cyc %0d: got %b want %b", i, outs(), exp_vec());
            end
            if (pressed === 1'b1 && rise < 0) rise = i;
        end
        tests++;
        if (rise != 6) begin
            fails++; $display("FAIL reset_press_delay: got %0d want 6", rise);
        end
        tests++;
        if (hold_active !== 1'b1) begin
            fails++; $display("FAIL reset_reach_held: got %b want 1", hold_active);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({pressed, hold_active} !== 2'b00) begin
            fails++; $display("FAIL async_reset: got %b want 00", {pressed, hold_active});
        end
        btn_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            tests++;
            if (outs() !== 5'b0) begin
                fails++; $display("FAIL post_reset_idle cyc %0d: got %b want 00000", i, outs());
            end
        end
    endtask

    task automatic test_glitch();
        run_press(3, 16, -1, -1);
        tests++;
        if (r_rise != -1) begin
            fails++; $display("FAIL glitch_pressed: rose at %0d want never", r_rise);
        end
        tests++;
        if (r_n_short + r_n_long + rep_times.size() != 0) begin
            fails++; $display("FAIL glitch_pulses: got %0d want 0", r_n_short + r_n_long + rep_times.size());
        end
        tests++;
        if (r_mm != 0) begin
            fails++; $display("FAIL glitch_model: %0d mismatching cycles want 0", r_mm);
        end
        run_press(4, 20, -1, -1);
        tests++;
        if (r_rise != 6) begin
            fails++; $display("FAIL min_press_delay: got %0d want 6", r_rise);
        end
        tests++;
        if (r_n_short != 1 || r_short_at != 11) begin
            fails++; $display("FAIL min_press_short: count %0d at %0d want 1 at 11", r_n_short, r_short_at);
        end
        tests++;
        if (r_mm != 0) begin
            fails++; $display("FAIL min_press_model: %0d mismatching cycles want 0", r_mm);
        end
    endtask

    task automatic test_short();
        run_press(10, 30, -1, -1);
        tests++;
        if (r_rise != 6 || r_fall != 16) begin
            fails++; $display("FAIL short_level: rise %0d fall %0d want 6 16", r_rise, r_fall);
        end
        tests++;
        if (r_n_short != 1 || r_short_at != r_fall + 1) begin
            fails++; $display("FAIL short_pulse: count %0d at %0d want 1 at %0d", r_n_short, r_short_at, r_fall + 1);
        end
        tests++;
        if (r_n_long != 0 || r_n_hold != 0) begin
            fails++; $display("FAIL short_no_long: long %0d hold %0d want 0 0", r_n_long, r_n_hold);
        end
        tests++;
        if (r_mm != 0) begin
            fails++; $display("FAIL short_model: %0d mismatching cycles want 0", r_mm);
        end
    endtask

    task automatic test_long_repeat();
        int exp_q[$];
        exp_q = '{25, 30, 35, 40};
        run_press(40, 60, -1, -1);
        tests++;
        if (r_n_long != 1 || r_long_at - r_rise != LNG) begin
            fails++; $display("FAIL long_time: count %0d rel %0d want 1 20", r_n_long, r_long_at - r_rise);
        end
        tests++;
        if (rep_times.size() != exp_q.size()) begin
            fails++; $display("FAIL repeat_count: got %0d want %0d", rep_times.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                tests++;
                if (rep_times[k] != exp_q[k]) begin
                    fails++; $display("FAIL repeat_time[%0d]: got %0d want %0d", k, rep_times[k], exp_q[k]);
                end
            end
        end
        tests++;
        if (r_hold_first - r_rise != 20 || r_hold_last - r_rise != 40 || r_n_hold != 21) begin
            fails++; $display("FAIL long_hold_span: %0d..%0d n %0d want 20..40 n 21",
                              r_hold_first - r_rise, r_hold_last - r_rise, r_n_hold);
        end
        tests++;
        if (r_n_short != 0) begin
            fails++; $display("FAIL long_no_short: got %0d want 0", r_n_short);
        end
        tests++;
        if (r_mm != 0) begin
            fails++; $display("FAIL long_model: %0d mismatching cycles want 0", r_mm);
        end
    endtask

    task automatic test_repeat_gating();
        int exp_q[$];
        exp_q = '{25, 40};
        run_press(40, 60, 27, 36);
        tests++;
        if (rep_times.size() != exp_q.size()) begin
            fails++; $display("FAIL gate_count: got %0d want %0d", rep_times.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                tests++;
                if (rep_times[k] != exp_q[k]) begin
                    fails++; $display("FAIL gate_time[%0d]: got %0d want %0d", k, rep_times[k], exp_q[k]);
                end
            end
        end
        tests++;
        if (r_n_hold != 21) begin
            fails++; $display("FAIL gate_hold: got %0d want 21", r_n_hold);
        end
        tests++;
        if (r_mm != 0) begin
            fails++; $display("FAIL gate_model: %0d mismatching cycles want 0", r_mm);
        end
    endtask

    task automatic test_boundary();
        run_press(19, 45, -1, -1);
        tests++;
        if (r_fall - r_rise != 19) begin
            fails++; $display("FAIL bound_fall: got %0d want 19", r_fall - r_rise);
        end
        tests++;
        if (r_n_long != 1 || r_long_at - r_rise != 20 || r_n_short != 0) begin
            fails++; $display("FAIL bound_tie: long %0d rel %0d short %0d want 1 20 0",
                              r_n_long, r_long_at - r_rise, r_n_short);
        end
        tests++;
        if (r_n_hold != 0 || rep_times.size() != 0) begin
            fails++; $display("FAIL bound_no_hold: hold %0d reps %0d want 0 0", r_n_hold, rep_times.size());
        end
        tests++;
        if (r_mm != 0) begin
            fails++; $display("FAIL bound_model: %0d mismatching cycles want 0", r_mm);
        end
        run_press(18, 45, -1, -1);
        tests++;
        if (r_n_long != 0 || r_n_short != 1 || r_short_at - r_rise != 19) begin
            fails++; $display("FAIL bound_minus1: long %0d short %0d rel %0d want 0 1 19",
                              r_n_long, r_n_short, r_short_at - r_rise);
        end
        run_press(20, 45, -1, -1);
        tests++;
        if (r_n_long != 1 || r_n_short != 0 || r_n_hold != 1 || rep_times.size() != 0) begin
            fails++; $display("FAIL bound_plus1: long %0d short %0d hold %0d reps %0d want 1 0 1 0",
                              r_n_long, r_n_short, r_n_hold, rep_times.size());
        end
    endtask

    task automatic test_random();
        int cycles, seg, seen_s, seen_l, seen_r;
        cycles = 0; seen_s = 0; seen_l = 0; seen_r = 0;
        while (cycles < 3000) begin
            btn_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) repeat_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) seg = int'($urandom_range(20, 70));
            else seg = int'($urandom_range(1, 12));
            for (int i = 0; i < seg; i++) begin
                @(negedge clk);
                cycles++;
                tests++;
                if (outs() !== exp_vec()) begin
                    fails++; $display("FAIL random cyc %0d: got %b want %b", cycles, outs(), exp_vec());
                end
                seen_s += int'(short_press);
                seen_l += int'(long_press);
                seen_r += int'(repeat_pulse);
                if ($urandom_range(0, 15) == 0) repeat_en = ~repeat_en;
            end
        end
        btn_n = 1'b1;
        repeat (40) @(negedge clk);
        tests++;
        if (outs() !== 5'b0) begin
            fails++; $display("FAIL random_settle: got %b want 00000", outs());
        end
        $display("[TB] random: %0d short, %0d long, %0d repeat pulses", seen_s, seen_l, seen_r);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_short();
        test_long_repeat();
        test_repeat_gating();
        test_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

endmodule
